reorder_buffer: RTL and testbench

//  Buffer with in-order allocation, out-of-order writing and in-order reading.
//  A reservation claims the next slot in sequence and returns its index. Data is

---
 rtl/reorder_buffer_pkg.sv | 11 +
 rtl/reorder_buffer.sv | 113 +++++++++++
 tb/tb_reorder_buffer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared helpers for the reorder buffer: wrap-around pointer arithmetic for
// slot counts that need not be a power of two.
package reorder_buffer_pkg;

    // Advance a slot pointer, returning to zero after the last slot.
    function automatic int unsigned wrap_inc(input int unsigned ptr,
                                             input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/reorder_buffer.sv
// Reorder buffer: slots are claimed in order, filled in any order by index,
// and drained in order once the head slot holds data.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 8,
    parameter int INDEX_WIDTH = $clog2(DEPTH)
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic                   full,
    output logic                   empty,
    input  logic                   reserve_enable,
    output logic [INDEX_WIDTH-1:0] reserve_index,
    input  logic                   write_enable,
    input  logic [INDEX_WIDTH-1:0] write_index,
    input  logic [WIDTH-1:0]       write_data,
    output logic                   write_error,
    input  logic                   read_enable,
    output logic                   read_valid,
    output logic [WIDTH-1:0]       read_data
);

    logic [INDEX_WIDTH-1:0] head_q, head_d;
    logic [INDEX_WIDTH-1:0] tail_q, tail_d;
    logic [DEPTH-1:0]       reserved_q, reserved_d;
    logic [DEPTH-1:0]       written_q, written_d;
    logic                   full_q, full_d;
    logic                   empty_q, empty_d;
    logic [WIDTH-1:0]       mem_q [DEPTH];

    logic [31:0] write_index_ext;
    logic        index_in_range;
    logic        write_ok;
    logic        do_reserve;
    logic        do_read;

    // An index beyond the last slot (possible when DEPTH is not a power of
    // two) can never name a reserved slot, so it is rejected like one.
    assign write_index_ext = 32'(write_index);
    assign index_in_range  = write_index_ext < 32'(DEPTH);

    assign write_error = write_enable &&
                         (!index_in_range ||
                          !reserved_q[write_index] ||
                          written_q[write_index]);
    assign write_ok    = write_enable && !write_error;

    assign read_valid    = reserved_q[head_q] && written_q[head_q];
    assign read_data     = mem_q[head_q];
    assign reserve_index = tail_q;
    assign full          = full_q;
    assign empty         = empty_q;

    // Full is registered, so a reserve in the same cycle as a pop at full
    // is still refused.
    assign do_reserve = reserve_enable && !full_q;
    assign do_read    = read_enable && read_valid;

    always_comb begin
        reserved_d = reserved_q;
        written_d  = written_q;
        head_d     = head_q;
        tail_d     = tail_q;

        // Head and tail coincide only when empty or full, and in both cases
        // at most one of pop/reserve can fire, so these updates never collide.
        if (do_read) begin
            reserved_d[head_q] = 1'b0;
            written_d[head_q]  = 1'b0;
            head_d             = INDEX_WIDTH'(wrap_inc(32'(head_q), DEPTH));
        end

        if (do_reserve) begin
            reserved_d[tail_q] = 1'b1;
            tail_d             = INDEX_WIDTH'(wrap_inc(32'(tail_q), DEPTH));
        end

        if (write_ok) begin
            written_d[write_index] = 1'b1;
        end

        full_d  = &reserved_d;
        empty_d = ~|reserved_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            reserved_q <= '0;
            written_q  <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            reserved_q <= reserved_d;
            written_q  <= written_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
        end
    end

    // Payload storage is not reset; the written[] flags gate its visibility.
    always_ff @(posedge clock) begin
        if (write_ok) begin
            mem_q[write_index] <= write_data;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer at DEPTH=4, WIDTH=8.
module tb_reorder_buffer;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int IW    = 2;

    logic             clock;
    logic             reset;
    logic             full;
    logic             empty;
    logic             reserve_enable;
    logic [IW-1:0]    reserve_index;
    logic             write_enable;
    logic [IW-1:0]    write_index;
    logic [WIDTH-1:0] write_data;
    logic             write_error;
    logic             read_enable;
    logic             read_valid;
    logic [WIDTH-1:0] read_data;

    int vectors;
    int miscompares;

    reorder_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .INDEX_WIDTH(IW)) dut (
        .clock         (clock),
        .reset         (reset),
        .full          (full),
        .empty         (empty),
        .reserve_enable(reserve_enable),
        .reserve_index (reserve_index),
        .write_enable  (write_enable),
        .write_index   (write_index),
        .write_data    (write_data),
        .write_error   (write_error),
        .read_enable   (read_enable),
        .read_valid    (read_valid),
        .read_data     (read_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        reset          = 1'b1;
        reserve_enable = 1'b0;
        write_enable   = 1'b0;
        write_index    = '0;
        write_data     = '0;
        read_enable    = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;

        // 1. reset state
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_rvalid", 32'(read_valid), 0);
        chk("rst_ridx", 32'(reserve_index), 0);
        chk("rst_werr", 32'(write_error), 0);

        // 2. fill all four slots
        for (int i = 0; i < 4; i++) begin
            reserve_enable = 1'b1;
            #1;
            chk($sformatf("res_idx%0d", i), 32'(reserve_index), 32'(i));
            tick();
        end
        reserve_enable = 1'b0;
        #1;
        chk("full_after4", 32'(full), 1);
        chk("empty_after4", 32'(empty), 0);
        reserve_enable = 1'b1;
        tick();
        reserve_enable = 1'b0;
        #1;
        chk("res5_ignored_tail", 32'(reserve_index), 0);
        chk("res5_still_full", 32'(full), 1);

        // 3. out-of-order writes
        write_enable = 1'b1; write_index = 2'd2; write_data = 8'hC2;
        #1;
        chk("w2_err", 32'(write_error), 0);
        tick();
        write_index = 2'd0; write_data = 8'hA0;
        #1;
        chk("rvalid_before_w0", 32'(read_valid), 0);
        chk("w0_err", 32'(write_error), 0);
        tick();
        write_index = 2'd1; write_data = 8'hB1;
        #1;
        chk("rvalid_after_w0", 32'(read_valid), 1);
        chk("rdata_head0", 32'(read_data), 32'h00A0);
        tick();

        // 4a. second write to an already written slot
        write_index = 2'd1; write_data = 8'hEE;
        #1;
        chk("dup_w1_err", 32'(write_error), 1);
        tick();
        write_enable = 1'b0;

        read_enable = 1'b1;
        #1;
        chk("rd0_data", 32'(read_data), 32'h00A0);
        tick();
        chk("rd1_valid", 32'(read_valid), 1);
        chk("rd1_data", 32'(read_data), 32'h00B1);
        tick();
        chk("rd2_data", 32'(read_data), 32'h00C2);
        tick();
        read_enable = 1'b0;
        #1;
        chk("head3_unwritten", 32'(read_valid), 0);
        chk("full_after_reads", 32'(full), 0);
        chk("empty_after_reads", 32'(empty), 0);

        // 4b. write to an unreserved slot
        write_enable = 1'b1; write_index = 2'd0; write_data = 8'h55;
        #1;
        chk("unres_w0_err", 32'(write_error), 1);
        tick();
        write_enable = 1'b0;
        #1;
        chk("unres_tail", 32'(reserve_index), 0);

        // 5. refill to full, then pop and reserve in the same cycle
        reserve_enable = 1'b1;
        tick(); tick(); tick();
        reserve_enable = 1'b0;
        #1;
        chk("refill_full", 32'(full), 1);
        chk("refill_tail", 32'(reserve_index), 3);
        write_enable = 1'b1; write_index = 2'd3; write_data = 8'hD3;
        tick();
        write_enable = 1'b0;
        read_enable = 1'b1; reserve_enable = 1'b1;
        #1;
        chk("pop3_valid", 32'(read_valid), 1);
        chk("pop3_data", 32'(read_data), 32'h00D3);
        tick();
        read_enable = 1'b0; reserve_enable = 1'b0;
        #1;
        chk("pop_full_cleared", 32'(full), 0);
        chk("pop_res_ignored", 32'(reserve_index), 3);
        chk("head0_unwritten", 32'(read_valid), 0);
        reserve_enable = 1'b1;
        #1;
        chk("freed_idx", 32'(reserve_index), 3);
        tick();
        reserve_enable = 1'b0;
        #1;
        chk("tail_wrap", 32'(reserve_index), 0);
        chk("full_again", 32'(full), 1);

        // write to head with read_enable in the same cycle
        write_enable = 1'b1; write_index = 2'd0; write_data = 8'h70; read_enable = 1'b1;
        #1;
        chk("whead_err", 32'(write_error), 0);
        chk("whead_rvalid", 32'(read_valid), 0);
        tick();
        write_enable = 1'b0; read_enable = 1'b0;
        #1;
        chk("whead_not_popped", 32'(full), 1);
        chk("whead_rvalid_next", 32'(read_valid), 1);
        chk("whead_data", 32'(read_data), 32'h0070);

        // 6. reset with three entries written
        write_enable = 1'b1; write_index = 2'd1; write_data = 8'h71;
        tick();
        write_index = 2'd2; write_data = 8'h72;
        tick();
        write_enable = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rst2_empty", 32'(empty), 1);
        chk("rst2_full", 32'(full), 0);
        chk("rst2_rvalid", 32'(read_valid), 0);
        chk("rst2_ridx", 32'(reserve_index), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
